// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states,
// reset PC and the bubble instruction word.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // PCs are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for a fetched instruction and its PC, used
// when a response arrives while ID is stalled.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding imem read
// handshake and fills IF/ID. Optional macro IF_DELAY_SLOT_EN keeps the
// fetch in flight at a redirect (branch delay slot) instead of flushing it.
//
// Handshake: a read is issued while imem_req=1 and is accepted in the cycle
// imem_ready=1; exactly one imem_rvalid pulse later returns its data, and no
// new request is issued until that response has been consumed.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  pc,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_pc_plus_4,
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_next;
  logic [31:0]  inflight_pc;
  logic         kill;
  logic         hold_valid;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc;

`ifdef IF_DELAY_SLOT_EN
  localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
  localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

  logic        redirect_flush;
  logic [31:0] redirect_target;
  logic        accept;
  logic        resp;
  logic        resp_use;
  logic        id_load_mem;
  logic        id_load_hold;
  logic        hold_load;
  logic        hold_clear;

  assign redirect_flush  = redirect && FLUSH_ON_REDIRECT;
  assign redirect_target = word_align(redirect_pc);
  assign accept          = (state == S_REQ) && imem_ready;
  assign resp            = (state == S_WAIT) && imem_rvalid;
  assign resp_use        = resp && !kill && !redirect_flush;
  assign id_load_mem     = resp_use && !stall;
  assign hold_load       = resp_use && stall;
  assign id_load_hold    = (state == S_HOLD) && hold_valid && !stall && !redirect_flush;
  assign hold_clear      = (state == S_HOLD) && (state_next == S_REQ);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next-state logic; a flushing redirect abandons S_HOLD and any arriving data,
  // but an accepted request still has to drain through S_WAIT.
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:  if (imem_ready) state_next = S_WAIT;
      S_WAIT: if (imem_rvalid) begin
                if (kill || redirect_flush || !stall) state_next = S_REQ;
                else                                  state_next = S_HOLD;
              end
      S_HOLD: if (!stall || redirect_flush) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state == S_REQ) && !rst;
    imem_addr = pc;
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst)         inflight_pc <= 32'h0;
    else if (accept) inflight_pc <= pc;
  end

`ifdef IF_DELAY_SLOT_EN
  logic        pend_redirect;
  logic [31:0] pend_pc;

  assign kill = 1'b0;

  // A redirect seen before the delay-slot request is accepted is parked
  // until that request goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      pend_redirect <= 1'b0;
      pend_pc       <= 32'h0;
    end else if (accept) begin
      if (redirect)           pc <= redirect_target;
      else if (pend_redirect) pc <= pend_pc;
      else                    pc <= pc + 32'd4;
      pend_redirect <= 1'b0;
    end else if (redirect) begin
      if (state == S_REQ) begin
        pend_redirect <= 1'b1;
        pend_pc       <= redirect_target;
      end else begin
        pc <= redirect_target;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      kill <= 1'b0;
    end else begin
      if (redirect)    pc <= redirect_target;
      else if (accept) pc <= pc + 32'd4;
      // Kill only a fetch whose response is still to come.
      if (redirect)  kill <= accept || ((state == S_WAIT) && !imem_rvalid);
      else if (resp) kill <= 1'b0;
    end
  end
`endif

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .clear      (hold_clear),
    .load       (hold_load),
    .load_instr (imem_rdata),
    .load_pc    (inflight_pc),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  // IF/ID register: frozen under stall, otherwise loads or takes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc        <= 32'h0;
      id_pc_plus_4 <= 32'd4;
    end else if (!stall) begin
      if (id_load_mem) begin
        id_valid     <= 1'b1;
        id_instr     <= imem_rdata;
        id_pc        <= inflight_pc;
        id_pc_plus_4 <= inflight_pc + 32'd4;
      end else if (id_load_hold) begin
        id_valid     <= 1'b1;
        id_instr     <= hold_instr;
        id_pc        <= hold_pc;
        id_pc_plus_4 <= hold_pc + 32'd4;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule
